// File: rtl/ahb_copy_master.sv
// ahb_copy_master
// AHB-Lite word-copy master. It takes a source address, a destination
// address and a word count, then moves the words one at a time. Each word
// is one single NONSEQ read followed by one single NONSEQ write, and it
// honours HREADY wait states in every phase. A one-cycle done pulse marks
// the end of the copy.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HADDR/HWDATA/HSIZE   AHB address, write data and size (size is always word)
//   HTRANS/HWRITE        AHB transfer type (IDLE/NONSEQ only) and direction
//   HRDATA/HREADY        slave read data and ready
//   start                one-cycle request, sampled only in IDLE
//   src_addr/dst_addr    byte addresses; bits [1:0] are ignored
//   length               number of words to copy (0 = finish at once)
//   busy                 high in every state except IDLE
//   done                 one-cycle completion pulse
//   dbg_state_o          current FSM state, exposed for checkers
//
// Handshake: a phase completes only on a rising HCLK edge where HREADY = 1.
// While HREADY = 0 every bus output holds its value. start is a plain
// single-cycle strobe with no ready; the block only looks at it in IDLE.
module ahb_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [31:0]      HADDR,
  output logic [31:0]      HWDATA,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR_A = 3'd3,
    S_WR_D = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t             state_q;
  logic [31:0]        src_ptr_q;
  logic [31:0]        dst_ptr_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [31:0]        data_q;
  logic [31:0]        haddr_q;
  logic [1:0]         htrans_q;
  logic               hwrite_q;
  logic               busy_q;
  logic               done_q;

  // The two low address bits are dropped on purpose: transfers are words.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  // Bus outputs and status all come straight from registers. They are set on
  // the edge that enters each state, so every address phase starts out clean.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_ptr_q   <= {src_addr[31:2], 2'b00};
            dst_ptr_q   <= {dst_addr[31:2], 2'b00};
            remaining_q <= length;
            busy_q      <= 1'b1;
            if (length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_RD_A;
              htrans_q <= TR_NONSEQ;
              haddr_q  <= {src_addr[31:2], 2'b00};
              hwrite_q <= 1'b0;
            end
          end
        end
        S_RD_A: begin
          if (HREADY) begin
            state_q  <= S_RD_D;
            htrans_q <= TR_IDLE;
          end
        end
        S_RD_D: begin
          if (HREADY) begin
            data_q   <= HRDATA;
            state_q  <= S_WR_A;
            htrans_q <= TR_NONSEQ;
            haddr_q  <= dst_ptr_q;
            hwrite_q <= 1'b1;
          end
        end
        S_WR_A: begin
          if (HREADY) begin
            state_q  <= S_WR_D;
            htrans_q <= TR_IDLE;
          end
        end
        S_WR_D: begin
          if (HREADY) begin
            src_ptr_q   <= src_ptr_q + 32'd4;
            dst_ptr_q   <= dst_ptr_q + 32'd4;
            remaining_q <= remaining_q - LEN_W'(1);
            hwrite_q    <= 1'b0;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // The next read address is the incremented source pointer.
              state_q  <= S_RD_A;
              htrans_q <= TR_NONSEQ;
              haddr_q  <= src_ptr_q + 32'd4;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          htrans_q <= TR_IDLE;
          hwrite_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign HADDR       = haddr_q;
  assign HWDATA      = data_q;
  assign HSIZE       = 3'b010;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master. The bench acts as the AHB slave and as the
// host that starts copies. For each copy it builds a list of expected bus
// cycles from the word-level copy rules, then drives HREADY/HRDATA from
// that list and checks the DUT outputs on every falling edge.
module tb_ahb_copy_master;
  localparam int LEN_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [2:0]       HSIZE;
  logic [1:0]       HTRANS;
  logic             HWRITE, HREADY, start, busy, done;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] length;
  logic [2:0]       state_unused;

  ahb_copy_master #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HRDATA(HRDATA),
    .HREADY(HREADY), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .dbg_state_o(state_unused)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic        chk_a;
    logic        chk_wr;
    logic        chk_wd;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        rdy;
    logic [31:0] rdata;
  } cyc_t;

  cyc_t        exp_q[$];
  int          wts[$];
  logic [31:0] mem [logic [31:0]];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] get_mem(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // One bus phase lasting w wait cycles plus the completing cycle.
  task automatic add_phase(input int w, input logic [1:0] tr, input logic [31:0] a,
                           input logic wr, input logic cw, input logic [31:0] wd,
                           input logic [31:0] rd);
    cyc_t c;
    for (int j = 0; j <= w; j++) begin
      c.trans = tr; c.addr = a; c.wr = wr; c.chk_a = 1'b1; c.chk_wr = 1'b1;
      c.chk_wd = cw; c.wdata = wd; c.busy = 1'b1; c.done = 1'b0;
      c.rdy = (j == w);
      c.rdata = (j == w) ? rd : $urandom;
      exp_q.push_back(c);
    end
  endtask

  task automatic set_waits(input int len, input bit rnd);
    wts.delete();
    for (int i = 0; i < 4 * len; i++)
      wts.push_back((rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
  endtask

  // Word-level model: word i reads src+4i and writes that value to dst+4i.
  task automatic build_model(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] s, d, sa, da, val;
    cyc_t c;
    exp_q.delete();
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      sa  = s + 32'(4 * i);
      da  = d + 32'(4 * i);
      val = get_mem(sa);
      add_phase(wts[4*i],   2'b10, sa, 1'b0, 1'b0, 32'h0, $urandom);
      add_phase(wts[4*i+1], 2'b00, sa, 1'b0, 1'b0, 32'h0, val);
      add_phase(wts[4*i+2], 2'b10, da, 1'b1, 1'b0, 32'h0, $urandom);
      add_phase(wts[4*i+3], 2'b00, da, 1'b1, 1'b1, val,   $urandom);
      mem[da] = val;
    end
    c.trans = 2'b00; c.addr = 32'h0; c.wr = 1'b0; c.chk_a = 1'b0; c.chk_wr = 1'b0;
    c.chk_wd = 1'b0; c.wdata = 32'h0; c.busy = 1'b1; c.done = 1'b1;
    c.rdy = 1'($urandom); c.rdata = $urandom;
    exp_q.push_back(c);
    c.busy = 1'b0; c.done = 1'b0; c.chk_wr = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic compare(input int k);
    cyc_t c;
    c = exp_q[k];
    chk("htrans", k, 32'(HTRANS), 32'(c.trans));
    chk("busy",   k, 32'(busy),   32'(c.busy));
    chk("done",   k, 32'(done),   32'(c.done));
    chk("hsize",  k, 32'(HSIZE),  32'h2);
    if (c.chk_a)  chk("haddr",  k, HADDR, c.addr);
    if (c.chk_wr) chk("hwrite", k, 32'(HWRITE), 32'(c.wr));
    if (c.chk_wd) chk("hwdata", k, HWDATA, c.wdata);
  endtask

  // Entered about 1 ns after a rising edge with the DUT in IDLE.
  task automatic run_model(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int mid_at, input int abort_at);
    start = 1'b1; src_addr = src; dst_addr = dst; length = LEN_W'(len);
    HREADY = 1'($urandom); HRDATA = $urandom;
    @(posedge HCLK); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      HREADY = exp_q[k].rdy;
      HRDATA = exp_q[k].rdata;
      if (k == mid_at) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom;
        length = LEN_W'($urandom_range(1, 9));
      end else begin
        start = 1'b0; src_addr = $urandom; dst_addr = $urandom; length = LEN_W'($urandom);
      end
      @(negedge HCLK);
      compare(k);
      if (k == abort_at) begin
        HRESETn = 1'b0;
        #1;
        chk("rst_htrans", k, 32'(HTRANS), 32'h0);
        chk("rst_busy",   k, 32'(busy),   32'h0);
        chk("rst_hwrite", k, 32'(HWRITE), 32'h0);
        for (int j = 0; j < 2; j++) begin
          @(negedge HCLK);
          chk("rst_done", k, 32'(done), 32'h0);
          chk("rst_busy_hold", k, 32'(busy), 32'h0);
        end
        start = 1'b0;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        return;
      end
      @(posedge HCLK); #1;
    end
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s, d;
    int len;
    HRESETn = 1'b0; start = 1'b0; HREADY = 1'b1; HRDATA = '0;
    src_addr = '0; dst_addr = '0; length = '0;
    #1;
    chk("reset_htrans", 0, 32'(HTRANS), 32'h0);
    chk("reset_haddr",  0, HADDR, 32'h0);
    chk("reset_hwrite", 0, 32'(HWRITE), 32'h0);
    chk("reset_hwdata", 0, HWDATA, 32'h0);
    chk("reset_busy",   0, 32'(busy), 32'h0);
    chk("reset_done",   0, 32'(done), 32'h0);
    chk("reset_hsize",  0, 32'(HSIZE), 32'h2);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // single word, no waits
    mem[32'h100] = 32'hDEADBEEF;
    set_waits(1, 1'b0);
    build_model(32'h100, 32'h200, 1);
    chk("pin1_size",  0, 32'(exp_q.size()), 32'd6);
    chk("pin1_done",  4, 32'(exp_q[4].done), 32'h1);
    chk("pin1_wdata", 3, exp_q[3].wdata, 32'hDEADBEEF);
    chk("pin1_raddr", 0, exp_q[0].addr, 32'h100);
    chk("pin1_waddr", 2, exp_q[2].addr, 32'h200);
    run_model(32'h100, 32'h200, 1, -1, -1);

    // three words with waits on word 2 read data and write address phases
    mem[32'h400] = 32'h11; mem[32'h404] = 32'h22; mem[32'h408] = 32'h33;
    set_waits(3, 1'b0);
    wts[5] = 2; wts[6] = 1;
    build_model(32'h400, 32'h800, 3);
    chk("pin2_done", 15, 32'(exp_q[15].done), 32'h1);
    chk("pin2_size", 0, 32'(exp_q.size()), 32'd17);
    run_model(32'h400, 32'h800, 3, -1, -1);
    chk("pin2_mem0", 0, mem[32'h800], 32'h11);
    chk("pin2_mem2", 0, mem[32'h808], 32'h33);

    // zero length
    set_waits(0, 1'b0);
    build_model(32'h40, 32'h80, 0);
    chk("pin3_size", 0, 32'(exp_q.size()), 32'd2);
    chk("pin3_done", 0, 32'(exp_q[0].done), 32'h1);
    run_model(32'h40, 32'h80, 0, -1, -1);

    // start pulsed again mid-copy, and in the DONE cycle
    set_waits(3, 1'b1);
    build_model(32'h1000, 32'h2000, 3);
    run_model(32'h1000, 32'h2000, 3, 5, -1);
    set_waits(2, 1'b0);
    build_model(32'h1100, 32'h2100, 2);
    run_model(32'h1100, 32'h2100, 2, 8, -1);

    // address wrap and unaligned source
    set_waits(3, 1'b0);
    build_model(32'hFFFFFFF8, 32'h3000, 3);
    chk("pin5_a0", 0, exp_q[0].addr, 32'hFFFFFFF8);
    chk("pin5_a1", 4, exp_q[4].addr, 32'hFFFFFFFC);
    chk("pin5_a2", 8, exp_q[8].addr, 32'h00000000);
    run_model(32'hFFFFFFF8, 32'h3000, 3, -1, -1);
    set_waits(1, 1'b0);
    build_model(32'h103, 32'h302, 1);
    chk("pin6_a", 0, exp_q[0].addr, 32'h100);
    run_model(32'h103, 32'h302, 1, -1, -1);

    // reset during the write address phase of word 2 of 4, then a full copy
    set_waits(4, 1'b0);
    build_model(32'h500, 32'h600, 4);
    chk("pin7_wra", 6, exp_q[6].addr, 32'h604);
    run_model(32'h500, 32'h600, 4, -1, 6);
    set_waits(4, 1'b1);
    build_model(32'h500, 32'h600, 4);
    run_model(32'h500, 32'h600, 4, -1, -1);

    // randomized copies
    for (int r = 0; r < 25; r++) begin
      s   = $urandom;
      d   = $urandom;
      len = $urandom_range(0, 6);
      set_waits(len, 1'b1);
      build_model(s, d, len);
      run_model(s, d, len,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, exp_q.size() - 2)) : -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
